// File: rtl/spart_pkg.sv
// spart_pkg: shared constants and state encodings for the SPART core.
//   ADDR_*      : ioaddr decode values
//   ST_*        : status register bit positions
//   OVERSAMPLE  : baud ticks per serial bit
//   tx_state_t / rx_state_t : transmit and receive FSM states
package spart_pkg;
    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DIVL = 2'b10;
    localparam logic [1:0] ADDR_DIVH = 2'b11;
    localparam int ST_TBR  = 0;
    localparam int ST_RDA  = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_FERR = 3;
    localparam int OVERSAMPLE = 16;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/spart_baud_gen.sv
// spart_baud_gen: programmable divisor and baud tick generator.
//   clk, rst      : clock, async active-low reset
//   wr_lo, wr_hi  : write strobes for divisor low/high byte
//   wdata         : byte written to the divisor
//   divisor       : current 16-bit divisor
//   tick          : one-cycle pulse every divisor+1 clocks
module spart_baud_gen #(
    parameter logic [15:0] RESET_DIV = 16'h00A3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [7:0]  wdata,
    output logic [15:0] divisor,
    output logic        tick
);
    logic [15:0] cnt;
    assign tick = cnt == divisor;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            divisor <= RESET_DIV;
            cnt     <= '0;
        end else begin
            if (wr_lo) divisor[7:0] <= wdata;
            if (wr_hi) divisor[15:8] <= wdata;
            cnt <= (wr_lo || wr_hi || tick) ? '0 : cnt + 16'd1;
        end
endmodule

// File: rtl/spart_core.sv
// spart_core: byte-wide serial port with bus decode, 8N1 transmitter and receiver.
//   clk, rst   : clock, async active-low reset
//   iocs, iorw, ioaddr, databus : driver bus (iorw=1 read)
//   rda, tbr   : receive data available, transmit buffer ready
//   txd, rxd   : serial lines
//   piso_out   : {tx_active, tx_shift} debug view
module spart_core
    import spart_pkg::*;
#(
    parameter logic [15:0] RESET_DIV   = 16'h00A3,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd,
    output logic [8:0] piso_out
);
    localparam logic [3:0] BIT_END = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] RX_MID  = 4'(OVERSAMPLE / 2 - 1);

    logic        wr, rd, rd_buf, rd_stat, tx_load, tick;
    logic [15:0] divisor;
    logic [7:0]  rd_data, status;
    tx_state_t   tx_state;
    logic [3:0]  tx_cnt;
    logic [2:0]  tx_bits;
    logic [7:0]  tx_shift;
    rx_state_t   rx_state;
    logic [SYNC_STAGES-1:0] sync;
    logic        rx_s, rx_prev, rx_end, rx_done, rx_bad, overrun, frame_err;
    logic [3:0]  rx_cnt;
    logic [2:0]  rx_bits;
    logic [7:0]  rx_shift, rx_buf;

    assign wr      = iocs && !iorw;
    assign rd      = iocs && iorw;
    assign rd_buf  = rd && ioaddr == ADDR_BUF;
    assign rd_stat = rd && ioaddr == ADDR_STAT;
    assign tx_load = wr && ioaddr == ADDR_BUF && tbr;

    spart_baud_gen #(.RESET_DIV(RESET_DIV)) u_baud (
        .clk(clk), .rst(rst),
        .wr_lo(wr && ioaddr == ADDR_DIVL), .wr_hi(wr && ioaddr == ADDR_DIVH),
        .wdata(databus), .divisor(divisor), .tick(tick)
    );

    always_comb begin
        status          = '0;
        status[ST_TBR]  = tbr;
        status[ST_RDA]  = rda;
        status[ST_OVR]  = overrun;
        status[ST_FERR] = frame_err;
        rd_data = ioaddr == ADDR_BUF  ? rx_buf :
                  ioaddr == ADDR_STAT ? status :
                  ioaddr == ADDR_DIVL ? divisor[7:0] : divisor[15:8];
    end

    assign databus  = rd ? rd_data : 8'hzz;
    assign piso_out = {tx_state != TX_IDLE, tx_shift};

    // tx_cnt is 4 bits wide, so it wraps back to 0 exactly at the end of each bit.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            tbr      <= 1'b1;
            txd      <= 1'b1;
        end else
            case (tx_state)
                TX_IDLE: if (tx_load) begin
                    tx_shift <= databus;
                    tbr      <= 1'b0;
                    txd      <= 1'b0;
                    tx_cnt   <= '0;
                    tx_state <= TX_START;
                end
                TX_START: if (tick) begin
                    tx_cnt <= tx_cnt + 4'd1;
                    if (tx_cnt == BIT_END) begin
                        txd      <= tx_shift[0];
                        tx_bits  <= '0;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: if (tick) begin
                    tx_cnt <= tx_cnt + 4'd1;
                    if (tx_cnt == BIT_END) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bits  <= tx_bits + 3'd1;
                        txd      <= tx_bits == 3'd7 ? 1'b1 : tx_shift[1];
                        if (tx_bits == 3'd7) tx_state <= TX_STOP;
                    end
                end
                default: if (tick) begin
                    tx_cnt <= tx_cnt + 4'd1;
                    if (tx_cnt == BIT_END) begin
                        tbr      <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                end
            endcase

    assign rx_s    = sync[SYNC_STAGES-1];
    assign rx_end  = rx_state == RX_STOP && tick && rx_cnt == BIT_END;
    assign rx_done = rx_end && rx_s;
    assign rx_bad  = rx_end && !rx_s;

    // A byte landing on the same edge as a buffer read keeps rda set and is not an overrun.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sync      <= '1;
            rx_prev   <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bits   <= '0;
            rx_shift  <= '0;
            rx_buf    <= '0;
            rda       <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], rxd};
            rx_prev   <= rx_s;
            rda       <= rx_done ? 1'b1 : rd_buf ? 1'b0 : rda;
            overrun   <= (rx_done && rda && !rd_buf) ? 1'b1 : rd_stat ? 1'b0 : overrun;
            frame_err <= rx_bad ? 1'b1 : rd_stat ? 1'b0 : frame_err;
            if (rx_done) rx_buf <= rx_shift;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_s) begin
                    rx_cnt   <= '0;
                    rx_state <= RX_START;
                end
                RX_START: if (tick) begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == RX_MID) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: if (tick) begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == BIT_END) begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 3'd1;
                        if (rx_bits == 3'd7) rx_state <= RX_STOP;
                    end
                end
                default: if (tick) begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == BIT_END) rx_state <= RX_IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_spart_core.sv
// tb_spart_core: self-checking bench for spart_core (register vectors, serial frames, random traffic).
module tb_spart_core;
    import spart_pkg::*;

    logic       clk = 1'b0, rst = 1'b0, iocs = 1'b0, iorw = 1'b0, rxd = 1'b1, den = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] dval = 8'h00;
    wire  [7:0] databus;
    logic       rda, tbr, txd;
    logic [8:0] piso_out;
    int         n_cmp = 0, n_bad = 0;

    assign databus = den ? dval : 8'hzz;
    always #5 clk = ~clk;

    spart_core dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
        .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd), .piso_out(piso_out)
    );

    typedef struct {
        bit         wr;
        logic [1:0] addr;
        logic [7:0] data;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; dval = d; den = 1'b1;
        @(negedge clk);
        iocs = 1'b0; den = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;
    endtask

    // Drives one 8N1 frame on rxd, bp clocks per bit.
    task automatic send_rx(input logic [7:0] b, input logic stop, input int bp);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = fr[k];
            repeat (bp) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    // Called on the negedge right after the load edge; records txd until tbr returns
    // and checks the frame shape: start 0, eight data bits LSB first, stop 1.
    task automatic tx_check(input logic [7:0] b, input int bp, input bit poke);
        logic s[$];
        logic [9:0] fr;
        int n, st, lo, bad, a0, a1, lim;
        fr  = {1'b1, b, 1'b0};
        lim = 12 * bp;
        n   = 0;
        chk("tbr_after_load", tbr, 0);
        chk("piso_after_load", piso_out, {1'b1, b});
        while (!tbr && n < lim) begin
            s.push_back(txd);
            if (poke && n == 100) begin
                iocs = 1'b1; iorw = 1'b0; ioaddr = ADDR_BUF; dval = ~b; den = 1'b1;
            end
            if (poke && n == 101) begin
                iocs = 1'b0; den = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= lim) begin
            n_bad++;
            $display("FAIL tx_timeout: tbr still 0 after %0d clocks, required within %0d", n, lim);
            return;
        end
        st = n - 9 * bp;
        lo = bp - bp / OVERSAMPLE + 1;
        n_cmp++;
        if (st < lo || st > bp) begin
            n_bad++;
            $display("FAIL tx_start_len: got %0d clocks, expected %0d..%0d", st, lo, bp);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            a0  = k == 0 ? 0 : st + (k - 1) * bp;
            a1  = k == 0 ? st : st + k * bp;
            bad = 0;
            for (int i = a0; i < a1; i++) if (s[i] !== fr[k]) bad++;
            chk($sformatf("tx_bit%0d_badsamples_byte%02h", k, b), bad, 0);
        end
        chk("tx_idle_txd", txd, 1);
    endtask

    initial begin
        vec_t       tbl[12];
        logic [7:0] r, cap, last, b;
        int         hits, d, bp, k;

        tbl = '{
            '{1'b0, ADDR_DIVL, 8'hA3}, '{1'b0, ADDR_DIVH, 8'h00}, '{1'b0, ADDR_STAT, 8'h01},
            '{1'b1, ADDR_DIVL, 8'h12}, '{1'b1, ADDR_DIVH, 8'h34}, '{1'b0, ADDR_DIVL, 8'h12},
            '{1'b0, ADDR_DIVH, 8'h34}, '{1'b1, ADDR_STAT, 8'hFF}, '{1'b0, ADDR_STAT, 8'h01},
            '{1'b1, ADDR_DIVL, 8'h03}, '{1'b1, ADDR_DIVH, 8'h00}, '{1'b0, ADDR_DIVL, 8'h03}
        };

        repeat (2) @(negedge clk);
        chk("rst_tbr", tbr, 1);
        chk("rst_rda", rda, 0);
        chk("rst_txd", txd, 1);
        chk("rst_piso", piso_out, 0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++)
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
            else begin
                bus_read(tbl[i].addr, r);
                chk($sformatf("tbl%0d", i), r, tbl[i].data);
            end

        // With iocs=0 the DUT must not drive: only the bench value may appear.
        @(negedge clk);
        iorw = 1'b1; ioaddr = ADDR_STAT; dval = 8'h00; den = 1'b1;
        #1 chk("hiz_stat", databus, 8'h00);
        ioaddr = ADDR_DIVL;
        #1 chk("hiz_divl", databus, 8'h00);
        den = 1'b0; iorw = 1'b0;

        bus_write(ADDR_BUF, 8'h5A);
        tx_check(8'h5A, 64, 1);

        send_rx(8'hC3, 1'b1, 64);
        chk("rx_c3_rda", rda, 1);
        bus_read(ADDR_BUF, r);
        chk("rx_c3_data", r, 8'hC3);
        chk("rx_c3_rda_clr", rda, 0);

        send_rx(8'h11, 1'b1, 64);
        send_rx(8'h22, 1'b1, 64);
        chk("ovr_rda", rda, 1);
        bus_read(ADDR_BUF, r);
        chk("ovr_data", r, 8'h22);
        bus_read(ADDR_STAT, r);
        chk("ovr_stat1", r, 8'h05);
        bus_read(ADDR_STAT, r);
        chk("ovr_stat2", r, 8'h01);

        // Buffer read held across the completing edge: rda is seen for exactly one cycle.
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = ADDR_BUF;
        hits = 0; cap = 8'h00;
        fork
            send_rx(8'h6B, 1'b1, 64);
            for (int i = 0; i < 640; i++) begin
                @(negedge clk);
                if (rda) begin
                    hits++;
                    cap = databus;
                end
            end
        join
        iocs = 1'b0; iorw = 1'b0;
        chk("simul_rda_cycles", hits, 1);
        chk("simul_data", cap, 8'h6B);
        bus_read(ADDR_STAT, r);
        chk("simul_stat", r, 8'h01);

        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (120) @(negedge clk);
        chk("glitch_rda", rda, 0);
        chk("glitch_rx_idle", int'(dut.rx_state), int'(RX_IDLE));

        send_rx(8'hA5, 1'b0, 64);
        chk("ferr_rda", rda, 0);
        bus_read(ADDR_STAT, r);
        chk("ferr_stat1", r, 8'h09);
        bus_read(ADDR_STAT, r);
        chk("ferr_stat2", r, 8'h01);

        bus_write(ADDR_BUF, 8'h3C);
        repeat (288) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_tbr", tbr, 1);
        chk("midrst_piso", piso_out, 0);
        @(negedge clk);
        rst = 1'b1;
        bus_read(ADDR_DIVL, r);
        chk("midrst_divl", r, 8'hA3);
        bus_write(ADDR_DIVL, 8'h03);
        bus_write(ADDR_BUF, 8'hFF);
        tx_check(8'hFF, 64, 0);

        for (int it = 0; it < 14; it++) begin
            d  = $urandom_range(0, 3);
            bp = (d + 1) * OVERSAMPLE;
            bus_write(ADDR_DIVL, 8'(d));
            bus_write(ADDR_DIVH, 8'h00);
            if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                bus_write(ADDR_BUF, b);
                tx_check(b, bp, 0);
            end else begin
                k = $urandom_range(1, 2);
                last = 8'h00;
                for (int j = 0; j < k; j++) begin
                    last = 8'($urandom);
                    send_rx(last, 1'b1, bp);
                end
                chk("rnd_rda", rda, 1);
                bus_read(ADDR_BUF, r);
                chk("rnd_rxbuf", r, last);
                chk("rnd_rda_clr", rda, 0);
                bus_read(ADDR_STAT, r);
                chk("rnd_status", r, k > 1 ? 8'h05 : 8'h01);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
